// File: rtl/fifo_rd_streamer.sv
// Read-side master for a dual-clock FIFO: issues rdreq, absorbs the fixed q latency in a skid buffer, presents a valid/ready stream.
// Latency: rdreq to m_valid is RD_LAT+1 rdclk cycles; 1 word/clk sustained once primed.
// Backpressure: rdreq is only issued while buffered + in-flight words < DEPTH, so m_ready=0 never overflows; optional RD_STATS_EN adds rd_cnt.
module fifo_rd_streamer #(
  parameter int DW     = 8,
  parameter int RD_LAT = 1,
  parameter int CW     = 16
) (
  input  logic          rdclk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          rdempty,
  output logic          rdreq,
  input  logic [DW-1:0] q,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          busy
`ifdef RD_STATS_EN
  ,
  output logic [CW-1:0] rd_cnt
`endif
);

  localparam int DEPTH = RD_LAT + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int OW    = $clog2(DEPTH + 1);
  localparam int DM1   = DEPTH - 1;
  localparam logic [PW-1:0] LAST    = DM1[PW-1:0];
  localparam logic [OW:0]   DEPTH_V = DEPTH[OW:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [OW-1:0]     occ;
  logic [RD_LAT-1:0] inflight;
  logic [OW-1:0]     inflight_cnt;
  logic [OW:0]       pend_cnt;
  logic              capture;
  logic              pop;

  // Count requests still travelling through the FIFO read pipeline.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + {{(OW-1){1'b0}}, inflight[i]};
    end
  end

  // Credit: a word popped this cycle does not free a slot until next cycle.
  assign pend_cnt = {1'b0, occ} + {1'b0, inflight_cnt};
  assign rdreq    = (state == RUN) && en && !rdempty && (pend_cnt < DEPTH_V);
  assign capture  = inflight[RD_LAT-1];
  assign m_valid  = (occ != '0);
  assign m_data   = mem[rd_ptr];
  assign pop      = m_valid && m_ready;
  assign busy     = m_valid || (inflight != '0);

  // FSM state register.
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: STOP lingers until every in-flight word has landed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = STOP;
      STOP: begin
        if (en) begin
          state_nxt = RUN;
        end else if (inflight == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // In-flight tracking, skid buffer storage, pointers and occupancy.
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 1; i < RD_LAT; i++) begin
        inflight[i] <= inflight[i-1];
      end
      inflight[0] <= rdreq;
      if (capture) begin
        mem[wr_ptr] <= q;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({capture, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef RD_STATS_EN
  // Delivered-word counter, wraps naturally at 2^CW.
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
    end else if (pop) begin
      rd_cnt <= rd_cnt + 1'b1;
    end
  end
`else
  logic [CW-1:0] cw_unused;
  assign cw_unused = '0;
`endif

endmodule
